codec_cfg_sequencer: RTL and testbench

- Parametrised successor to the fixed-table codec register writer.
- Walks a configuration table of NUM_REGS (sub-address, data) entries and issues one write command per entry to the I2C master.
- Advances on the master's NewCom completion handshake; adds NACK retry, response timeout, inter-command gap, abort, and done/error status.
- Sits between the external config ROM/LUT and the I2C master; clocked in the I2C_clk domain.

---
 rtl/codec_cfg_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_codec_cfg_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer
//
// Purpose:
//   Walks a NUM_REGS-entry (sub-address, data) configuration table and issues
//   one write command per entry to the I2C master. Each command completes on
//   the master's NewCom pulse. A NACK or a response timeout triggers a retry
//   of the same entry, up to MAX_RETRY extra attempts. An optional idle gap
//   separates a completion from the next write. Sticky done/error status is
//   reported, and abort returns the sequencer to IDLE from any state.
//   Lives entirely in the I2C_clk domain.
//
// Ports:
//   I2C_clk   in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   start     in   one-cycle pulse; begins the sequence at entry 0 (ignored while busy)
//   abort     in   synchronous return to IDLE; beats start and NewCom
//   NewCom    in   master pulse: previous command finished
//   ack_err   in   qualifies NewCom; 1 = slave NACKed
//   tbl_idx   out  current table index, drives the external table
//   tbl_addr  in   sub-address at tbl_idx (combinational lookup)
//   tbl_data  in   data at tbl_idx (combinational lookup)
//   write     out  one-cycle command strobe to the master
//   SubAddrL  out  registered sub-address of the current command
//   data      out  registered data of the current command
//   busy      out  sequence in progress
//   done      out  sticky: whole table written
//   error     out  sticky: retries exhausted
//   fail_idx  out  index of the entry that exhausted its retries
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start (after reset or abort)
// ISSUE | latch the table entry, raise write
// WAIT  | command in flight, waiting for NewCom or timeout
// GAP   | idle spacing before the next write / retry
// DONE  | every entry acknowledged
// FAIL  | an entry ran out of retries
module codec_cfg_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 11,
  parameter int IDX_W      = 4,
  parameter int MAX_RETRY  = 3,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              I2C_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              NewCom,
  input  logic              ack_err,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  output logic              write,
  output logic [ADDR_W-1:0] SubAddrL,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [IDX_W-1:0]  fail_idx
);

  localparam int RETRY_W = (MAX_RETRY > 0)  ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES)    : 1;
  localparam int TMO_W   = (TIMEOUT > 1)    ? $clog2(TIMEOUT)       : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic               TMO_EN     = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_t;

  // With no gap configured, a completed attempt goes straight back to ISSUE.
  localparam state_t S_AFTER_WAIT = (GAP_CYCLES == 0) ? S_ISSUE : S_GAP;

  state_t              r_state,    w_state_nxt;
  logic [IDX_W-1:0]    r_idx,      w_idx_nxt;
  logic [RETRY_W-1:0]  r_retry,    w_retry_nxt;
  logic [GAP_W-1:0]    r_gap_cnt,  w_gap_cnt_nxt;
  logic [TMO_W-1:0]    r_tmo_cnt,  w_tmo_cnt_nxt;
  logic                r_write,    w_write_nxt;
  logic [ADDR_W-1:0]   r_sub_addr, w_sub_addr_nxt;
  logic [DATA_W-1:0]   r_data,     w_data_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                r_done,     w_done_nxt;
  logic                r_error,    w_error_nxt;
  logic [IDX_W-1:0]    r_fail_idx, w_fail_idx_nxt;

  logic w_resp;
  logic w_ok;
  logic w_attempt_bad;
  logic w_tmo_hit;

  // The master may still be reporting the previous command while write is
  // high, so a completion is only accepted from the second WAIT cycle on.
  assign w_resp        = (r_state == S_WAIT) && NewCom && !r_write;
  assign w_ok          = w_resp && !ack_err;
  assign w_tmo_hit     = TMO_EN && (r_state == S_WAIT) && (r_tmo_cnt == TMO_LAST);
  // A real response always wins over a coincident timeout expiry.
  assign w_attempt_bad = (w_resp && ack_err) || (!w_resp && w_tmo_hit);

  always_ff @(posedge I2C_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_retry_nxt    = r_retry;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_write_nxt    = 1'b0;
    w_sub_addr_nxt = r_sub_addr;
    w_data_nxt     = r_data;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;
    w_fail_idx_nxt = r_fail_idx;

    if (abort) begin
      // Payload registers keep the last command; status is left untouched.
      w_state_nxt = S_IDLE;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            w_state_nxt = S_ISSUE;
            w_idx_nxt   = '0;
            w_retry_nxt = '0;
            w_done_nxt  = 1'b0;
            w_error_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
          end
        end

        S_ISSUE: begin
          w_sub_addr_nxt = tbl_addr;
          w_data_nxt     = tbl_data;
          w_write_nxt    = 1'b1;
          w_tmo_cnt_nxt  = '0;
          w_state_nxt    = S_WAIT;
        end

        S_WAIT: begin
          if (w_ok) begin
            if (r_idx == IDX_LAST) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
            end else begin
              w_idx_nxt     = r_idx + 1'b1;
              w_retry_nxt   = '0;
              w_gap_cnt_nxt = '0;
              w_state_nxt   = S_AFTER_WAIT;
            end
          end else if (w_attempt_bad) begin
            if (r_retry == RETRY_LAST) begin
              w_state_nxt    = S_FAIL;
              w_error_nxt    = 1'b1;
              w_fail_idx_nxt = r_idx;
              w_busy_nxt     = 1'b0;
            end else begin
              w_retry_nxt   = r_retry + 1'b1;
              w_gap_cnt_nxt = '0;
              w_state_nxt   = S_AFTER_WAIT;
            end
          end else if (TMO_EN) begin
            w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + 1'b1;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge I2C_clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_retry    <= '0;
      r_gap_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_write    <= 1'b0;
      r_sub_addr <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_fail_idx <= '0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_retry    <= w_retry_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_write    <= w_write_nxt;
      r_sub_addr <= w_sub_addr_nxt;
      r_data     <= w_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_fail_idx <= w_fail_idx_nxt;
    end
  end

  assign tbl_idx  = r_idx;
  assign write    = r_write;
  assign SubAddrL = r_sub_addr;
  assign data     = r_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign fail_idx = r_fail_idx;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer: 4-entry table, 2-cycle gap,
// 16-cycle timeout, 3 retries. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, away from the edge.
module tb_codec_cfg_sequencer;

  localparam int NUM_REGS   = 4;
  localparam int IDX_W      = 2;
  localparam int MAX_RETRY  = 3;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 16;
  localparam int LAT        = 8;                        // write edge to NewCom sampling edge
  localparam int SPACE_ACK  = LAT + GAP_CYCLES + 1;     // 11
  localparam int SPACE_TMO  = TIMEOUT + GAP_CYCLES + 1; // 19

  logic             I2C_clk = 1'b0;
  logic             reset, start, abort, NewCom, ack_err;
  logic [IDX_W-1:0] tbl_idx, fail_idx;
  logic [7:0]       tbl_addr, tbl_data, SubAddrL, data;
  logic             write, busy, done, error;

  logic [7:0] tab_addr [NUM_REGS] = '{8'h00, 8'h02, 8'h08, 8'h0C};
  logic [7:0] tab_data [NUM_REGS] = '{8'h17, 8'h79, 8'h12, 8'h00};

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  assign tbl_addr = tab_addr[tbl_idx];
  assign tbl_data = tab_data[tbl_idx];

  codec_cfg_sequencer #(
    .ADDR_W(8), .DATA_W(8), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W),
    .MAX_RETRY(MAX_RETRY), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .I2C_clk(I2C_clk), .reset(reset), .start(start), .abort(abort),
    .NewCom(NewCom), .ack_err(ack_err), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .write(write),
    .SubAddrL(SubAddrL), .data(data), .busy(busy), .done(done),
    .error(error), .fail_idx(fail_idx)
  );

  always #5 I2C_clk = ~I2C_clk;
  always @(posedge I2C_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge I2C_clk);
    #1;
  endtask

  task automatic pulse_start(output int s_cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
  endtask

  // Stops on the cycle where write is seen high (without stepping past it).
  task automatic wait_write(input int budget, output bit found, output int w_cyc);
    found = 1'b0;
    w_cyc = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (write) begin
        found = 1'b1;
        w_cyc = cyc;
      end else begin
        tick();
      end
    end
  endtask

  // Called on the write cycle; NewCom is sampled lat edges after the write edge.
  task automatic respond(input int lat, input logic nack);
    repeat (lat - 1) tick();
    NewCom  = 1'b1;
    ack_err = nack;
    tick();
    NewCom  = 1'b0;
    ack_err = 1'b0;
  endtask

  task automatic count_writes(input int ncyc, output int nw);
    nw = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (write) nw++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; NewCom = 1'b0; ack_err = 1'b0;
    repeat (3) tick();
    n_total++; if ({write, busy, done, error} !== 4'b0000) $display("FAIL reset_status: got %b want 0000", {write, busy, done, error}); else n_pass++;
    n_total++; if ({SubAddrL, data} !== 16'h0000) $display("FAIL reset_payload: got %h want 0000", {SubAddrL, data}); else n_pass++;
    n_total++; if ({tbl_idx, fail_idx} !== '0) $display("FAIL reset_idx: got %b want 0", {tbl_idx, fail_idx}); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    bit f; int s, w, wprev;
    wprev = 0;
    pulse_start(s);
    n_total++; if (busy !== 1'b1) $display("FAIL nom_busy_start: got %b want 1", busy); else n_pass++;
    for (int e = 0; e < NUM_REGS; e++) begin
      wait_write(40, f, w);
      n_total++; if (!f) $display("FAIL nom_write_seen[%0d]: got none want write", e); else n_pass++;
      if (e == 0) begin
        n_total++; if (w - s !== 1) $display("FAIL nom_first_latency: got %0d want 1", w - s); else n_pass++;
      end else begin
        n_total++; if (w - wprev !== SPACE_ACK) $display("FAIL nom_spacing[%0d]: got %0d want %0d", e, w - wprev, SPACE_ACK); else n_pass++;
      end
      wprev = w;
      n_total++; if ({SubAddrL, data} !== {tab_addr[e], tab_data[e]}) $display("FAIL nom_payload[%0d]: got %h want %h", e, {SubAddrL, data}, {tab_addr[e], tab_data[e]}); else n_pass++;
      n_total++; if (tbl_idx !== IDX_W'(e)) $display("FAIL nom_idx[%0d]: got %0d want %0d", e, tbl_idx, e); else n_pass++;
      tick();
      n_total++; if (write !== 1'b0) $display("FAIL nom_write_width[%0d]: got %b want 0", e, write); else n_pass++;
      respond(LAT - 1, 1'b0);
    end
    n_total++; if ({done, busy, error} !== 3'b100) $display("FAIL nom_end_status: got %b want 100", {done, busy, error}); else n_pass++;
  endtask

  task automatic test_nack_retry();
    int ent [6] = '{0, 1, 1, 1, 2, 3};
    bit nk  [6] = '{0, 1, 1, 0, 0, 0};
    bit f; int s, w, wprev, nw;
    wprev = 0;
    pulse_start(s);
    n_total++; if (done !== 1'b0) $display("FAIL nack_done_clear: got %b want 0", done); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      wait_write(40, f, w);
      n_total++; if (!f) $display("FAIL nack_write_seen[%0d]: got none want write", k); else n_pass++;
      if (k > 0) begin
        n_total++; if (w - wprev !== SPACE_ACK) $display("FAIL nack_spacing[%0d]: got %0d want %0d", k, w - wprev, SPACE_ACK); else n_pass++;
      end
      wprev = w;
      n_total++; if ({SubAddrL, data} !== {tab_addr[ent[k]], tab_data[ent[k]]}) $display("FAIL nack_payload[%0d]: got %h want %h", k, {SubAddrL, data}, {tab_addr[ent[k]], tab_data[ent[k]]}); else n_pass++;
      respond(LAT, nk[k]);
    end
    n_total++; if ({done, busy, error} !== 3'b100) $display("FAIL nack_end_status: got %b want 100", {done, busy, error}); else n_pass++;
    count_writes(20, nw);
    n_total++; if (nw !== 0) $display("FAIL nack_extra_writes: got %0d want 0", nw); else n_pass++;
  endtask

  task automatic test_retry_exhaust();
    int ent [6] = '{0, 1, 2, 2, 2, 2};
    bit nk  [6] = '{0, 0, 1, 1, 1, 1};
    bit f; int s, w, nw;
    pulse_start(s);
    for (int k = 0; k < 6; k++) begin
      wait_write(40, f, w);
      n_total++; if (!f) $display("FAIL exh_write_seen[%0d]: got none want write", k); else n_pass++;
      n_total++; if ({SubAddrL, data} !== {tab_addr[ent[k]], tab_data[ent[k]]}) $display("FAIL exh_payload[%0d]: got %h want %h", k, {SubAddrL, data}, {tab_addr[ent[k]], tab_data[ent[k]]}); else n_pass++;
      respond(LAT, nk[k]);
    end
    n_total++; if ({error, busy, done} !== 3'b100) $display("FAIL exh_status: got %b want 100", {error, busy, done}); else n_pass++;
    n_total++; if (fail_idx !== 2'd2) $display("FAIL exh_fail_idx: got %0d want 2", fail_idx); else n_pass++;
    count_writes(40, nw);
    n_total++; if (nw !== 0) $display("FAIL exh_extra_writes: got %0d want 0", nw); else n_pass++;
  endtask

  task automatic test_timeout();
    bit f; int s, w, wprev;
    wprev = 0;
    pulse_start(s);
    n_total++; if (error !== 1'b0) $display("FAIL tmo_error_clear: got %b want 0", error); else n_pass++;
    for (int k = 0; k < MAX_RETRY + 1; k++) begin
      wait_write(40, f, w);
      n_total++; if (!f) $display("FAIL tmo_write_seen[%0d]: got none want write", k); else n_pass++;
      if (k > 0) begin
        n_total++; if (w - wprev !== SPACE_TMO) $display("FAIL tmo_spacing[%0d]: got %0d want %0d", k, w - wprev, SPACE_TMO); else n_pass++;
      end
      wprev = w;
      n_total++; if ({SubAddrL, data} !== {tab_addr[0], tab_data[0]}) $display("FAIL tmo_payload[%0d]: got %h want %h", k, {SubAddrL, data}, {tab_addr[0], tab_data[0]}); else n_pass++;
      if (k < MAX_RETRY) tick();
    end
    repeat (TIMEOUT - 1) tick();
    n_total++; if ({error, busy} !== 2'b01) $display("FAIL tmo_before_expiry: got %b want 01", {error, busy}); else n_pass++;
    tick();
    n_total++; if ({error, busy, done} !== 3'b100) $display("FAIL tmo_fail_status: got %b want 100", {error, busy, done}); else n_pass++;
    n_total++; if (fail_idx !== 2'd0) $display("FAIL tmo_fail_idx: got %0d want 0", fail_idx); else n_pass++;
  endtask

  task automatic test_abort();
    bit f; int s, w, nw;
    pulse_start(s);
    for (int e = 0; e < 2; e++) begin
      wait_write(40, f, w);
      n_total++; if (!f) $display("FAIL abt_write_seen[%0d]: got none want write", e); else n_pass++;
      respond(LAT, 1'b0);
    end
    n_total++; if ({busy, tbl_idx} !== {1'b1, 2'd2}) $display("FAIL abt_in_gap: got %b want 110", {busy, tbl_idx}); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++; if ({busy, write, done, error} !== 4'b0000) $display("FAIL abt_status: got %b want 0000", {busy, write, done, error}); else n_pass++;
    n_total++; if ({SubAddrL, data} !== 16'h0279) $display("FAIL abt_payload_hold: got %h want 0279", {SubAddrL, data}); else n_pass++;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL abt_beats_start: got %b want 0", busy); else n_pass++;
    count_writes(30, nw);
    n_total++; if (nw !== 0) $display("FAIL abt_no_writes: got %0d want 0", nw); else n_pass++;
    pulse_start(s);
    wait_write(40, f, w);
    n_total++; if (!f) $display("FAIL abt_restart_seen: got none want write"); else n_pass++;
    n_total++; if ({tbl_idx, SubAddrL, data} !== {2'd0, 16'h0017}) $display("FAIL abt_restart_entry0: got %h want 00017", {tbl_idx, SubAddrL, data}); else n_pass++;
    respond(LAT, 1'b0);
    for (int e = 1; e < NUM_REGS; e++) begin
      wait_write(40, f, w);
      respond(LAT, 1'b0);
    end
    n_total++; if ({done, busy} !== 2'b10) $display("FAIL abt_rerun_done: got %b want 10", {done, busy}); else n_pass++;
  endtask

  task automatic test_stray_and_reset();
    bit f; int s, w, w0, nw;
    for (int i = 0; i < 3; i++) begin
      NewCom = 1'b1; ack_err = i[0];
      tick();
      NewCom = 1'b0; ack_err = 1'b0;
      tick();
    end
    count_writes(20, nw);
    n_total++; if (nw !== 0) $display("FAIL stray_done_writes: got %0d want 0", nw); else n_pass++;
    n_total++; if ({done, busy, tbl_idx} !== {1'b1, 1'b0, 2'd3}) $display("FAIL stray_done_state: got %b want 1011", {done, busy, tbl_idx}); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      NewCom = 1'b1;
      tick();
      NewCom = 1'b0;
      tick();
    end
    count_writes(20, nw);
    n_total++; if ({nw != 0, busy} !== 2'b00) $display("FAIL stray_idle: got writes=%0d busy=%b want 0 0", nw, busy); else n_pass++;
    // start pulses during WAIT and GAP must not restart the sequence
    pulse_start(s);
    wait_write(40, f, w0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    respond(LAT - 2, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_write(40, f, w);
    n_total++; if (!f) $display("FAIL busy_start_write_seen: got none want write"); else n_pass++;
    n_total++; if (w - w0 !== SPACE_ACK) $display("FAIL busy_start_spacing: got %0d want %0d", w - w0, SPACE_ACK); else n_pass++;
    n_total++; if ({tbl_idx, SubAddrL, data} !== {2'd1, 16'h0279}) $display("FAIL busy_start_entry1: got %h want 10279", {tbl_idx, SubAddrL, data}); else n_pass++;
    // asynchronous reset in the middle of WAIT
    repeat (2) tick();
    #3;
    reset = 1'b1;
    #1;
    n_total++; if ({write, busy, done, error} !== 4'b0000) $display("FAIL rst_mid_status: got %b want 0000", {write, busy, done, error}); else n_pass++;
    n_total++; if ({SubAddrL, data} !== 16'h0000) $display("FAIL rst_mid_payload: got %h want 0000", {SubAddrL, data}); else n_pass++;
    n_total++; if ({tbl_idx, fail_idx} !== '0) $display("FAIL rst_mid_idx: got %b want 0", {tbl_idx, fail_idx}); else n_pass++;
    tick();
    reset = 1'b0;
    count_writes(30, nw);
    n_total++; if ({nw != 0, busy} !== 2'b00) $display("FAIL rst_needs_start: got writes=%0d busy=%b want 0 0", nw, busy); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; NewCom = 1'b0; ack_err = 1'b0;
    test_reset();
    test_nominal();
    test_nack_retry();
    test_retry_exhaust();
    test_timeout();
    test_abort();
    test_stray_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
